// File: rtl/adc_spi_responder_if.sv
// Serial ADC bus between the board ADC controller (master) and the
// responder model (slave). All three controller-driven lines are
// asynchronous to the responder's system clock.
interface adc_spi_responder_if;
    logic ADC_SCLK;
    logic ADC_CS_N;
    logic ADC_DIN;
    logic ADC_DOUT;

    modport master (
        output ADC_SCLK,
        output ADC_CS_N,
        output ADC_DIN,
        input  ADC_DOUT
    );

    modport slave (
        input  ADC_SCLK,
        input  ADC_CS_N,
        input  ADC_DIN,
        output ADC_DOUT
    );
endinterface

// File: rtl/adc_spi_responder.sv
// Responder for an 8-channel 12-bit serial ADC with ADC128S022-style
// framing. The controller's SCLK/CS_N/DIN are oversampled on CLOCK; the
// channel address sent in one frame selects the data returned in the next.
module adc_spi_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int BITS_PER_FRAME = 16
) (
    input  logic                CLOCK,
    input  logic                RESET,
    adc_spi_responder_if.slave  adc,
    input  logic [11:0]         CH0,
    input  logic [11:0]         CH1,
    input  logic [11:0]         CH2,
    input  logic [11:0]         CH3,
    input  logic [11:0]         CH4,
    input  logic [11:0]         CH5,
    input  logic [11:0]         CH6,
    input  logic [11:0]         CH7,
    output logic                FRAME_DONE,
    output logic [2:0]          LAST_ADDR,
    output logic                FRAME_ERR
);

    typedef enum logic [1:0] {IDLE, ACTIVE, WRAP} state_t;

    localparam logic [3:0] LAST_BIT = 4'(BITS_PER_FRAME - 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   din_s;
    logic                   sclk_d;
    logic                   cs_d;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_fall;
    logic                   cs_rise;

    state_t      state, state_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [15:0] shift_reg, shift_nxt;
    logic [2:0]  addr_next, addr_next_nxt;
    logic [2:0]  cur_addr, cur_addr_nxt;
    logic [2:0]  last_addr_q, last_addr_nxt;
    logic        dout_q, dout_nxt;
    logic        done_q, done_nxt;
    logic        err_q, err_nxt;
    logic [11:0] ch_sel;
    logic [15:0] load_word;

    // Synchronizer chains plus one extra delayed copy for edge detection;
    // CS resets high so a held-low chip select does not look like a new frame.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            din_sync  <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], adc.ADC_SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], adc.ADC_CS_N};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], adc.ADC_DIN};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    // Channel mux feeding the shift register at frame load time only, so
    // later changes on CHn cannot disturb a frame already in flight.
    always_comb begin
        ch_sel = CH0;
        case (cur_addr)
            3'd0: ch_sel = CH0;
            3'd1: ch_sel = CH1;
            3'd2: ch_sel = CH2;
            3'd3: ch_sel = CH3;
            3'd4: ch_sel = CH4;
            3'd5: ch_sel = CH5;
            3'd6: ch_sel = CH6;
            3'd7: ch_sel = CH7;
            default: ch_sel = CH0;
        endcase
    end

    assign load_word = {4'b0000, ch_sel};

    // Frame FSM register bank.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            addr_next   <= '0;
            cur_addr    <= '0;
            last_addr_q <= '0;
            dout_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift_reg   <= shift_nxt;
            addr_next   <= addr_next_nxt;
            cur_addr    <= cur_addr_nxt;
            last_addr_q <= last_addr_nxt;
            dout_q      <= dout_nxt;
            done_q      <= done_nxt;
            err_q       <= err_nxt;
        end
    end

    // Next-state logic: CS rise is checked before SCLK edges so it always wins.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift_reg;
        addr_next_nxt = addr_next;
        cur_addr_nxt  = cur_addr;
        last_addr_nxt = last_addr_q;
        dout_nxt      = dout_q;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;

        case (state)
            IDLE: begin
                dout_nxt    = 1'b0;
                bit_cnt_nxt = '0;
                if (cs_fall) begin
                    shift_nxt = load_word;
                    dout_nxt  = load_word[15];
                    state_nxt = ACTIVE;
                end
            end

            ACTIVE: begin
                if (cs_rise) begin
                    err_nxt     = (bit_cnt != 4'd0);
                    dout_nxt    = 1'b0;
                    bit_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else if (sclk_rise) begin
                    case (bit_cnt)
                        4'd2: addr_next_nxt[2] = din_s;
                        4'd3: addr_next_nxt[1] = din_s;
                        4'd4: addr_next_nxt[0] = din_s;
                        default: ;
                    endcase
                    if (bit_cnt == LAST_BIT) begin
                        cur_addr_nxt  = addr_next_nxt;
                        last_addr_nxt = addr_next_nxt;
                        done_nxt      = 1'b1;
                        bit_cnt_nxt   = '0;
                        state_nxt     = WRAP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end else if (sclk_fall && bit_cnt != 4'd0) begin
                    shift_nxt = {shift_reg[14:0], 1'b0};
                    dout_nxt  = shift_reg[14];
                end
            end

            WRAP: begin
                if (cs_rise) begin
                    dout_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (sclk_fall) begin
                    shift_nxt = load_word;
                    dout_nxt  = load_word[15];
                    state_nxt = ACTIVE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign adc.ADC_DOUT = dout_q;
    assign FRAME_DONE   = done_q;
    assign FRAME_ERR    = err_q;
    assign LAST_ADDR    = last_addr_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: the initial block plays the ADC controller
// and queues expected words/addresses; independent monitors compare.
module tb_adc_spi_responder;

    localparam int HALF = 8;

    logic        clock;
    logic        reset;
    logic [11:0] ch [8];
    logic        frame_done;
    logic [2:0]  last_addr;
    logic        frame_err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] exp_word_q[$];
    logic [2:0]  exp_addr_q[$];
    logic [2:0]  exp_err_q[$];

    logic [15:0] rx_word;
    int          rx_cnt;

    adc_spi_responder_if adc_bus ();

    adc_spi_responder #(
        .SYNC_STAGES    (2),
        .BITS_PER_FRAME (16)
    ) dut (
        .CLOCK      (clock),
        .RESET      (reset),
        .adc        (adc_bus.slave),
        .CH0        (ch[0]),
        .CH1        (ch[1]),
        .CH2        (ch[2]),
        .CH3        (ch[3]),
        .CH4        (ch[4]),
        .CH5        (ch[5]),
        .CH6        (ch[6]),
        .CH7        (ch[7]),
        .FRAME_DONE (frame_done),
        .LAST_ADDR  (last_addr),
        .FRAME_ERR  (frame_err)
    );

    // Free-running system clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drive nrises SCLK periods, sending addr on rises 3..5; optionally
    // rewrite CH0 right after rise mod_at.
    task automatic apply_rises(input logic [2:0] addr, input int nrises,
                               input int mod_at, input logic [11:0] mod_val);
        for (int i = 0; i < nrises; i++) begin
            case (i)
                2: adc_bus.ADC_DIN = addr[2];
                3: adc_bus.ADC_DIN = addr[1];
                4: adc_bus.ADC_DIN = addr[0];
                default: adc_bus.ADC_DIN = 1'b0;
            endcase
            wait_clks(HALF);
            adc_bus.ADC_SCLK = 1'b1;
            if (i + 1 == mod_at) ch[0] = mod_val;
            wait_clks(HALF);
            adc_bus.ADC_SCLK = 1'b0;
        end
        adc_bus.ADC_DIN = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [2:0] addr, input logic [15:0] exp_word);
        exp_word_q.push_back(exp_word);
        exp_addr_q.push_back(addr);
        apply_rises(addr, 16, 0, 12'h000);
    endtask

    task automatic end_frame();
        wait_clks(HALF);
        adc_bus.ADC_CS_N = 1'b1;
        wait_clks(2 * HALF);
    endtask

    // Serial word monitor: assembles DOUT at each SCLK rise while selected.
    always @(posedge adc_bus.ADC_SCLK or posedge adc_bus.ADC_CS_N) begin
        if (adc_bus.ADC_CS_N) begin
            rx_cnt = 0;
        end else begin
            rx_word = {rx_word[14:0], adc_bus.ADC_DOUT};
            rx_cnt++;
            if (rx_cnt == 16) begin
                rx_cnt = 0;
                if (exp_word_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL dout_word: got %0h expected no frame", rx_word);
                end else begin
                    check_output("dout_word", rx_word, exp_word_q.pop_front());
                end
            end
        end
    end

    // Pulse monitor: every FRAME_DONE/FRAME_ERR cycle consumes one expectation.
    always @(negedge clock) begin
        if (frame_done) begin
            if (exp_addr_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL frame_done: got pulse expected none");
            end else begin
                check_output("last_addr", 16'(last_addr), 16'(exp_addr_q.pop_front()));
            end
        end
        if (frame_err) begin
            if (exp_err_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL frame_err: got pulse expected none");
            end else begin
                check_output("err_last_addr", 16'(last_addr), 16'(exp_err_q.pop_front()));
            end
        end
    end

    initial begin
        rx_word = '0;
        rx_cnt  = 0;
        reset   = 1'b1;
        adc_bus.ADC_SCLK = 1'b0;
        adc_bus.ADC_CS_N = 1'b1;
        adc_bus.ADC_DIN  = 1'b0;
        ch[0] = 12'hABC; ch[1] = 12'h001; ch[2] = 12'h2C4; ch[3] = 12'h333;
        ch[4] = 12'h444; ch[5] = 12'h5A3; ch[6] = 12'h666; ch[7] = 12'hFFF;
        wait_clks(5);
        check_output("rst_dout", 16'(adc_bus.ADC_DOUT), 16'h0);
        check_output("rst_done", 16'(frame_done), 16'h0);
        check_output("rst_err", 16'(frame_err), 16'h0);
        check_output("rst_last", 16'(last_addr), 16'h0);
        reset = 1'b0;
        wait_clks(5);

        $display("[TB] first frame after reset, address 5");
        adc_bus.ADC_CS_N = 1'b0;
        apply_stimulus(3'd5, 16'h0ABC);
        end_frame();
        check_output("idle_dout", 16'(adc_bus.ADC_DOUT), 16'h0);

        $display("[TB] second frame, address 2");
        adc_bus.ADC_CS_N = 1'b0;
        apply_stimulus(3'd2, 16'h05A3);
        end_frame();

        $display("[TB] continuous conversion, addresses 7 1 0");
        adc_bus.ADC_CS_N = 1'b0;
        apply_stimulus(3'd7, 16'h02C4);
        apply_stimulus(3'd1, 16'h0FFF);
        apply_stimulus(3'd0, 16'h0001);
        end_frame();

        $display("[TB] abort after 7 rises, address 6");
        exp_err_q.push_back(3'd0);
        adc_bus.ADC_CS_N = 1'b0;
        apply_rises(3'd6, 7, 0, 12'h000);
        end_frame();
        check_output("abort_dout", 16'(adc_bus.ADC_DOUT), 16'h0);
        check_output("abort_last", 16'(last_addr), 16'h0);

        $display("[TB] snapshot: CH0 changes at bit 8");
        ch[0] = 12'h123;
        exp_word_q.push_back(16'h0123);
        exp_addr_q.push_back(3'd0);
        adc_bus.ADC_CS_N = 1'b0;
        apply_rises(3'd0, 16, 8, 12'h456);
        end_frame();
        adc_bus.ADC_CS_N = 1'b0;
        apply_stimulus(3'd3, 16'h0456);
        end_frame();

        $display("[TB] reset at bit 10");
        adc_bus.ADC_CS_N = 1'b0;
        apply_rises(3'd5, 10, 0, 12'h000);
        reset = 1'b1;
        wait_clks(1);
        check_output("midrst_dout", 16'(adc_bus.ADC_DOUT), 16'h0);
        check_output("midrst_last", 16'(last_addr), 16'h0);
        check_output("midrst_done", 16'(frame_done), 16'h0);
        check_output("midrst_err", 16'(frame_err), 16'h0);
        adc_bus.ADC_CS_N = 1'b1;
        wait_clks(8);
        reset = 1'b0;
        wait_clks(4);

        $display("[TB] frame after reset returns CH0");
        adc_bus.ADC_CS_N = 1'b0;
        apply_stimulus(3'd4, 16'h0456);
        end_frame();

        wait_clks(20);
        check_output("left_words", 16'(exp_word_q.size()), 16'h0);
        check_output("left_done", 16'(exp_addr_q.size()), 16'h0);
        check_output("left_err", 16'(exp_err_q.size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
